// File: rtl/ddc_capture_ctrl.sv
// ddc_capture_ctrl: capture sequencer behind the DDC output.
// After a start command it optionally waits for a resync pulse. It then gates
// exactly len samples of the (non-stallable) DDC stream onto an AXI4-Stream
// master, with TLAST on the final sample. Samples that meet a blocked output
// slot are dropped and flagged in the sticky overflow bit.
// Optional feature macro: DDC_CAP_TIMEOUT_EN (ARMED-state timeout counter).
//
// Handshake: a word transfers on a cycle where m_axis_tvalid && m_axis_tready.
// tvalid/tdata/tlast stay stable until that cycle. tvalid never depends on
// tready, and it drops after a transfer unless a new sample loads in the
// same cycle.
`timescale 1ns/1ps

module ddc_capture_ctrl #(
  parameter int DATA_WIDTH     = 96,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  dev_clk,
  input  logic                  dev_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  wait_resync,
  input  logic [CNT_WIDTH-1:0]  num_samples,
  input  logic                  resync,
  input  logic [DATA_WIDTH-1:0] ddc_data,
  input  logic                  ddc_valid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  sample_count,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_overflow;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;

  logic w_handshake;
  logic w_slot_free;
  logic w_sample;
  logic w_load;
  logic w_last;
  logic w_start;

  assign w_handshake = r_tvalid & m_axis_tready;
  // The slot can take a new word if it is empty or its word leaves this cycle.
  assign w_slot_free = ~r_tvalid | m_axis_tready;
  // abort outranks a sample arriving in the same cycle.
  assign w_sample    = (r_state == S_CAPTURE) & ddc_valid & ~abort;
  assign w_load      = w_sample & w_slot_free;
  assign w_last      = (r_count == (r_len - 1'b1));
  assign w_start     = (r_state == S_IDLE) & start & ~abort;

`ifdef DDC_CAP_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_to_hit;

  assign w_to_hit = (r_state == S_ARMED) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // ARMED-time counter (held at zero outside ARMED) and the sticky timeout flag
  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state != S_ARMED) r_to_cnt <= '0;
      else                    r_to_cnt <= r_to_cnt + 1'b1;
      if (w_start)                            r_timeout <= 1'b0;
      else if (w_to_hit && !resync && !abort) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  // Feature compiled out: the timeout bit is a constant 0. The parameter only
  // appears here so that both builds share one parameter list.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Sequencer: command decode, sample counting, drain and completion
  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_len      <= num_samples;
              r_count    <= '0;
              r_overflow <= 1'b0;
              if (num_samples == '0) r_state <= S_DONE;
              else if (wait_resync)  r_state <= S_ARMED;
              else                   r_state <= S_CAPTURE;
            end
          end
          S_ARMED: begin
            if (resync) r_state <= S_CAPTURE;
`ifdef DDC_CAP_TIMEOUT_EN
            else if (w_to_hit) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
`endif
          end
          S_CAPTURE: begin
            if (ddc_valid) begin
              if (r_count != '1) r_count <= r_count + 1'b1;
              if (!w_slot_free)  r_overflow <= 1'b1;
              if (w_last)        r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (w_slot_free) r_state <= S_DONE;
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Output slot: load on an accepted sample, otherwise empty on handshake
  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_load) begin
      r_tdata  <= ddc_data;
      r_tvalid <= 1'b1;
      r_tlast  <= w_last;
    end else if (w_handshake) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign overflow      = r_overflow;
  assign sample_count  = r_count;
  assign dbg_state     = r_state;

endmodule
